// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    // Ordered so that a numerically larger kind has higher redirect priority
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2,
        REDIR_EXC    = 2'd3
    } redir_kind_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;
    localparam logic [31:0] INSTR_BYTES          = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_select.sv
// Combinational redirect priority mux: live exception > jump > branch > pending > sequential,
// with word-alignment checking of jump/branch targets.
module next_pc_select
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic [31:0] current_address,
    input  logic        exception,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  redir_kind_e pend_kind,
    input  logic [31:0] pend_target,
    output logic [31:0] sel_target,
    output redir_kind_e live_kind,
    output logic [31:0] live_target,
    output logic        live_mis,
    output logic [31:0] mis_target
);

    logic [31:0] seq_target_s;
    logic [31:0] jb_target_s;
    logic        jb_live_s;

    assign seq_target_s = current_address + INSTR_BYTES;
    assign jb_target_s  = jump ? jump_target : branch_target;
    assign jb_live_s    = jump | branch_taken;
    assign live_mis     = jb_live_s & is_misaligned(jb_target_s);
    assign mis_target   = jb_target_s;

    // Classify this cycle's live redirect; a misaligned jump/branch becomes an exception
    always_comb begin
        live_kind   = REDIR_NONE;
        live_target = seq_target_s;
        if (exception || live_mis) begin
            live_kind   = REDIR_EXC;
            live_target = EXC_VECTOR;
        end else if (jump) begin
            live_kind   = REDIR_JUMP;
            live_target = jump_target;
        end else if (branch_taken) begin
            live_kind   = REDIR_BRANCH;
            live_target = branch_target;
        end else begin
            live_kind   = REDIR_NONE;
            live_target = seq_target_s;
        end
    end

    // Final target: live redirect, else pending redirect, else sequential
    always_comb begin
        sel_target = seq_target_s;
        if (live_kind != REDIR_NONE) begin
            sel_target = live_target;
        end else if (pend_kind != REDIR_NONE) begin
            sel_target = pend_target;
        end else begin
            sel_target = seq_target_s;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side controller: boot sequence, fetch handshake, HALT state, pending redirect and EPC.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic        input_clock,
    input  logic        reset,
    input  logic [31:0] current_address,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic        halt_instr,
    input  logic        resume,
    output logic [31:0] next_address,
    output logic        pc_hold,
    output logic        imem_req,
    output logic        fetch_valid,
    output logic [31:0] epc,
    output logic        addr_error,
    output logic        halted
);

    pc_state_e   state_q, state_d;
    redir_kind_e pend_kind_q, pend_kind_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] sel_target_s;
    redir_kind_e live_kind_s;
    logic [31:0] live_target_s;
    logic        live_mis_s;
    logic [31:0] mis_target_s;
    logic        update_s;

    next_pc_select #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_select (
        .current_address (current_address),
        .exception       (exception),
        .jump            (jump),
        .jump_target     (jump_target),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .pend_kind       (pend_kind_q),
        .pend_target     (pend_target_q),
        .sel_target      (sel_target_s),
        .live_kind       (live_kind_s),
        .live_target     (live_target_s),
        .live_mis        (live_mis_s),
        .mis_target      (mis_target_s)
    );

    // State, pending redirect and EPC registers
    always_ff @(posedge input_clock) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pend_kind_q   <= REDIR_NONE;
            pend_target_q <= 32'h0000_0000;
            epc_q         <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pend_kind_q   <= pend_kind_d;
            pend_target_q <= pend_target_d;
            epc_q         <= epc_d;
        end
    end

    // Next-state, pending-redirect bookkeeping and fetch-side outputs
    always_comb begin
        state_d       = state_q;
        pend_kind_d   = pend_kind_q;
        pend_target_d = pend_target_q;
        epc_d         = epc_q;
        next_address  = current_address;
        pc_hold       = 1'b1;
        imem_req      = 1'b0;
        fetch_valid   = 1'b0;
        addr_error    = 1'b0;
        halted        = 1'b0;
        update_s      = 1'b0;

        if (reset) begin
            next_address = RESET_VECTOR;
            pc_hold      = 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    next_address = RESET_VECTOR;
                    pc_hold      = 1'b0;
                    state_d      = ST_FETCH;
                end
                ST_FETCH, ST_HALTED: begin
                    addr_error = live_mis_s;
                    halted     = (state_q == ST_HALTED);
                    if (state_q == ST_FETCH) begin
                        imem_req = ~stall;
                        update_s = ~stall & imem_ready;
                    end else begin
                        imem_req = 1'b0;
                        update_s = 1'b0;
                    end

                    // EPC keeps the first fault while an exception is still outstanding
                    if ((live_kind_s == REDIR_EXC) && (pend_kind_q != REDIR_EXC)) begin
                        epc_d = exception ? current_address : mis_target_s;
                    end else begin
                        epc_d = epc_q;
                    end

                    if (update_s) begin
                        fetch_valid  = 1'b1;
                        pc_hold      = 1'b0;
                        next_address = sel_target_s;
                        pend_kind_d  = REDIR_NONE;
                    end else if ((live_kind_s != REDIR_NONE) && (live_kind_s >= pend_kind_q)) begin
                        pend_kind_d   = live_kind_s;
                        pend_target_d = live_target_s;
                    end else begin
                        pend_kind_d = pend_kind_q;
                    end

                    if (state_q == ST_FETCH) begin
                        if (halt_instr && (live_kind_s != REDIR_EXC)) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else if ((live_kind_s == REDIR_EXC) || resume) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_HALTED;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        input_clock;
    logic        reset;
    logic [31:0] current_address;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic        halt_instr;
    logic        resume;
    logic [31:0] next_address;
    logic        pc_hold;
    logic        imem_req;
    logic        fetch_valid;
    logic [31:0] epc;
    logic        addr_error;
    logic        halted;

    int n_checks;
    int n_fail;

    pc_sequencer dut (
        .input_clock     (input_clock),
        .reset           (reset),
        .current_address (current_address),
        .imem_ready      (imem_ready),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .exception       (exception),
        .halt_instr      (halt_instr),
        .resume          (resume),
        .next_address    (next_address),
        .pc_hold         (pc_hold),
        .imem_req        (imem_req),
        .fetch_valid     (fetch_valid),
        .epc             (epc),
        .addr_error      (addr_error),
        .halted          (halted)
    );

    initial input_clock = 1'b0;
    always #5 input_clock = ~input_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge input_clock);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] exp_next);
        #1;
        check_eq({tag, "_next"}, next_address, exp_next);
        check_eq({tag, "_fv"}, 32'(fetch_valid), 32'd1);
        check_eq({tag, "_hold"}, 32'(pc_hold), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        current_address = 32'h0000_1234;
        imem_ready    = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        exception     = 1'b0;
        halt_instr    = 1'b0;
        resume        = 1'b0;
        tick();
        tick();

        // Outputs while reset is asserted
        #1;
        check_eq("rst_next", next_address, 32'h0);
        check_eq("rst_hold", 32'(pc_hold), 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_fv", 32'(fetch_valid), 32'd0);
        check_eq("rst_aerr", 32'(addr_error), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_epc", epc, 32'h0);

        // Boot cycle then sequential fetch
        reset = 1'b0;
        current_address = 32'h0;
        #1;
        check_eq("boot_next", next_address, 32'h0);
        check_eq("boot_hold", 32'(pc_hold), 32'd0);
        check_eq("boot_req", 32'(imem_req), 32'd0);
        check_eq("boot_fv", 32'(fetch_valid), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            current_address = 32'(i * 4);
            chk_fetch("seq", 32'(i * 4 + 4));
            tick();
        end

        // Jump latched while memory not ready
        current_address = 32'h40;
        imem_ready = 1'b0;
        #1;
        check_eq("wait_hold", 32'(pc_hold), 32'd1);
        check_eq("wait_fv", 32'(fetch_valid), 32'd0);
        check_eq("wait_req", 32'(imem_req), 32'd1);
        tick();
        jump = 1'b1;
        jump_target = 32'h100;
        #1;
        check_eq("wait_jmp_hold", 32'(pc_hold), 32'd1);
        tick();
        jump = 1'b0;
        tick();
        imem_ready = 1'b1;
        chk_fetch("pend_jmp", 32'h100);
        tick();
        current_address = 32'h100;
        chk_fetch("after_jmp", 32'h104);
        tick();

        // Exception beats jump and branch in the same cycle
        current_address = 32'h50;
        exception = 1'b1;
        jump = 1'b1;
        jump_target = 32'h200;
        branch_taken = 1'b1;
        branch_target = 32'h300;
        chk_fetch("exc_prio", 32'h8000_0180);
        check_eq("exc_aerr", 32'(addr_error), 32'd0);
        tick();
        exception = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;
        check_eq("exc_epc", epc, 32'h50);
        current_address = 32'h8000_0180;
        chk_fetch("exc_seq", 32'h8000_0184);
        tick();

        // Misaligned branch target
        current_address = 32'h60;
        branch_taken = 1'b1;
        branch_target = 32'h102;
        chk_fetch("mis_next", 32'h8000_0180);
        check_eq("mis_aerr", 32'(addr_error), 32'd1);
        tick();
        branch_taken = 1'b0;
        check_eq("mis_epc", epc, 32'h102);
        current_address = 32'h8000_0180;
        #1;
        check_eq("mis_aerr_clr", 32'(addr_error), 32'd0);
        tick();

        // HALT, five frozen cycles, resume
        current_address = 32'h20;
        imem_ready = 1'b0;
        halt_instr = 1'b1;
        #1;
        check_eq("halt_cyc_halted", 32'(halted), 32'd0);
        tick();
        halt_instr = 1'b0;
        imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("halted", 32'(halted), 32'd1);
            check_eq("halted_req", 32'(imem_req), 32'd0);
            check_eq("halted_hold", 32'(pc_hold), 32'd1);
            check_eq("halted_fv", 32'(fetch_valid), 32'd0);
            tick();
        end
        resume = 1'b1;
        #1;
        check_eq("resume_cyc_halted", 32'(halted), 32'd1);
        tick();
        resume = 1'b0;
        check_eq("resumed_halted", 32'(halted), 32'd0);
        chk_fetch("resumed", 32'h24);
        tick();

        // HALT with exception in the same cycle: exception wins, latched pending
        current_address = 32'h24;
        imem_ready = 1'b0;
        halt_instr = 1'b1;
        exception = 1'b1;
        tick();
        halt_instr = 1'b0;
        exception = 1'b0;
        check_eq("halt_exc_halted", 32'(halted), 32'd0);
        check_eq("halt_exc_epc", epc, 32'h24);
        imem_ready = 1'b1;
        chk_fetch("halt_exc_pend", 32'h8000_0180);
        tick();

        // Exception while HALTED, then a jump must not displace it
        current_address = 32'h30;
        imem_ready = 1'b0;
        halt_instr = 1'b1;
        tick();
        halt_instr = 1'b0;
        exception = 1'b1;
        #1;
        check_eq("hexc_halted", 32'(halted), 32'd1);
        tick();
        exception = 1'b0;
        jump = 1'b1;
        jump_target = 32'h400;
        #1;
        check_eq("hexc_left", 32'(halted), 32'd0);
        check_eq("hexc_hold", 32'(pc_hold), 32'd1);
        tick();
        jump = 1'b0;
        imem_ready = 1'b1;
        chk_fetch("hexc_keep", 32'h8000_0180);
        check_eq("hexc_epc", epc, 32'h30);
        tick();
        current_address = 32'h8000_0180;
        chk_fetch("hexc_clr", 32'h8000_0184);
        tick();

        // Stall with memory ready
        current_address = 32'h80;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("stall_req", 32'(imem_req), 32'd0);
            check_eq("stall_hold", 32'(pc_hold), 32'd1);
            check_eq("stall_fv", 32'(fetch_valid), 32'd0);
            tick();
        end
        stall = 1'b0;
        chk_fetch("unstall", 32'h84);
        tick();

        // Sequential wrap at the top of the address space
        current_address = 32'hFFFF_FFFC;
        chk_fetch("wrap", 32'h0);
        tick();

        // Reset while HALTED
        current_address = 32'h90;
        imem_ready = 1'b0;
        halt_instr = 1'b1;
        tick();
        halt_instr = 1'b0;
        #1;
        check_eq("prerst_halted", 32'(halted), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("midrst_halted", 32'(halted), 32'd0);
        check_eq("midrst_next", next_address, 32'h0);
        check_eq("midrst_hold", 32'(pc_hold), 32'd0);
        tick();
        reset = 1'b0;
        imem_ready = 1'b1;
        #1;
        check_eq("reboot_fv", 32'(fetch_valid), 32'd0);
        check_eq("reboot_next", next_address, 32'h0);
        check_eq("reboot_epc", epc, 32'h0);
        tick();
        current_address = 32'h0;
        chk_fetch("reboot_seq", 32'h4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
